// File: rtl/tx_frame_scheduler.sv
// Shares one bit-serial TX line between two byte sources: arbitrates, sends the
// sync marker, shifts payload bytes MSB-first, then pads with a zero gap.
module tx_frame_scheduler #(
  parameter int                   ASM_WIDTH    = 16,
  parameter logic [ASM_WIDTH-1:0] ASM          = 16'hEB90,
  parameter int                   GAP_BITS     = 1000,
  parameter int                   MAX_LEN      = 274,
  parameter int                   STARVE_LIMIT = 4
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] Req,
  input  logic [8:0] Len0,
  input  logic [8:0] Len1,
  input  logic [7:0] ByteData0,
  input  logic [7:0] ByteData1,
  output logic [1:0] ByteRd,
  output logic [1:0] Grant,
  output logic       DataO,
  output logic       Active,
  output logic       Busy,
  output logic       FrameDone,
  output logic       Err
);
  // state     | meaning
  // S_IDLE    | line quiet, arbitrating on Req
  // S_ASM     | sync marker bit on DataO
  // S_PAYLOAD | payload bit on DataO
  // S_GAP     | zero gap bit on DataO
  // S_ERR     | rejected grant cycle, returns to idle
  typedef enum logic [2:0] {S_IDLE, S_ASM, S_PAYLOAD, S_GAP, S_ERR} state_t;

  localparam int PAY_BITS = 8 * MAX_LEN;
  localparam int MAX_A    = (PAY_BITS > GAP_BITS) ? PAY_BITS : GAP_BITS;
  localparam int CNT_MAX  = (MAX_A > ASM_WIDTH) ? MAX_A : ASM_WIDTH;
  localparam int CW_RAW   = $clog2(CNT_MAX + 1);
  localparam int CW       = (CW_RAW > 12) ? CW_RAW : 12;
  localparam int SW_RAW   = $clog2(STARVE_LIMIT + 1);
  localparam int SW       = (SW_RAW > 1) ? SW_RAW : 1;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [ASM_WIDTH-1:0] asm_sh, asm_sh_n;
  logic [7:0]           shreg, shreg_n;
  logic [8:0]           len_q, len_n;
  logic                 src, src_n;
  logic [SW-1:0]        starve, starve_n;
  logic [1:0]           grant_n, byte_rd_n;
  logic                 data_n, active_n, busy_n, frame_done_n, err_n;

  logic       starve_full, pick1, len_bad;
  logic [8:0] len_sel;
  logic [7:0] byte_cur;

  assign starve_full = (starve == SW'(STARVE_LIMIT));
  assign pick1       = Req[1] & (~Req[0] | starve_full);
  assign len_sel     = pick1 ? Len1 : Len0;
  assign len_bad     = (len_sel == 9'd0) || (int'(len_sel) > MAX_LEN);
  assign byte_cur    = src ? ByteData1 : ByteData0;

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    asm_sh_n     = asm_sh;
    shreg_n      = shreg;
    len_n        = len_q;
    src_n        = src;
    starve_n     = starve;
    grant_n      = 2'b00;
    data_n       = 1'b0;
    active_n     = 1'b0;
    busy_n       = 1'b0;
    frame_done_n = 1'b0;
    err_n        = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|Req) begin
          src_n   = pick1;
          len_n   = len_sel;
          grant_n = pick1 ? 2'b10 : 2'b01;
          if (pick1 || !Req[1]) starve_n = '0;
          else if (!starve_full) starve_n = starve + 1'b1;
          if (len_bad) begin
            state_n = S_ERR;
            err_n   = 1'b1;
          end else begin
            state_n  = S_ASM;
            cnt_n    = CW'(ASM_WIDTH - 1);
            data_n   = ASM[ASM_WIDTH-1];
            asm_sh_n = ASM << 1;
            active_n = 1'b1;
            busy_n   = 1'b1;
          end
        end
      end
      S_ASM: begin
        active_n = 1'b1;
        busy_n   = 1'b1;
        if (cnt == '0) begin
          // byte 0 was read on this cycle; its MSB leads the payload
          state_n = S_PAYLOAD;
          cnt_n   = CW'({len_q, 3'b000}) - CW'(1);
          shreg_n = byte_cur;
          data_n  = byte_cur[7];
        end else begin
          cnt_n    = cnt - 1'b1;
          data_n   = asm_sh[ASM_WIDTH-1];
          asm_sh_n = asm_sh << 1;
        end
      end
      S_PAYLOAD: begin
        busy_n = 1'b1;
        if (cnt == '0) begin
          state_n      = S_GAP;
          cnt_n        = CW'(GAP_BITS - 1);
          frame_done_n = 1'b1;
        end else begin
          active_n = 1'b1;
          cnt_n    = cnt - 1'b1;
          if (cnt[2:0] == 3'd0) begin
            shreg_n = byte_cur;
            data_n  = byte_cur[7];
          end else begin
            data_n = shreg[cnt[2:0] - 3'd1];
          end
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          busy_n = 1'b1;
          cnt_n  = cnt - 1'b1;
        end
      end
      S_ERR: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // read strobe leads the cycle in which the source byte is consumed
    byte_rd_n = 2'b00;
    if ((state_n == S_ASM && cnt_n == '0) ||
        (state_n == S_PAYLOAD && cnt_n[2:0] == 3'd0 && cnt_n != '0))
      byte_rd_n = src_n ? 2'b10 : 2'b01;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      asm_sh    <= '0;
      shreg     <= '0;
      len_q     <= '0;
      src       <= 1'b0;
      starve    <= '0;
      Grant     <= 2'b00;
      ByteRd    <= 2'b00;
      DataO     <= 1'b0;
      Active    <= 1'b0;
      Busy      <= 1'b0;
      FrameDone <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      asm_sh    <= asm_sh_n;
      shreg     <= shreg_n;
      len_q     <= len_n;
      src       <= src_n;
      starve    <= starve_n;
      Grant     <= grant_n;
      ByteRd    <= byte_rd_n;
      DataO     <= data_n;
      Active    <= active_n;
      Busy      <= busy_n;
      FrameDone <= frame_done_n;
      Err       <= err_n;
    end
  end
endmodule

// File: doc/tx_frame_scheduler.md
# tx_frame_scheduler

Serial downlink frame scheduler for the TTC FPGA. It shares the single bit-serial TX line between two byte-oriented frame sources: source 0 is real-time telemetry, source 1 is the IP/test packet. For each granted frame it emits the attached sync marker, pulls the payload bytes from the granted source and shifts them out MSB-first at one bit per clock. It then inserts a zero-filled inter-frame gap. Its output feeds the modulator in place of a fixed-pattern generator.

## Interface
Parameters:
- ASM_WIDTH, 16: sync marker length in bits.
- ASM, 16'hEB90: sync marker value, sent MSB first.
- GAP_BITS, 1000: zero bits inserted after each frame (≥1).
- MAX_LEN, 274: maximum payload length in bytes.
- STARVE_LIMIT, 4: number of consecutive source-0 grants allowed while source 1 is waiting.

Ports:
- Clk  in  1  system clock. One clock domain; all logic is on the rising edge.
- Rst  in  1  synchronous, active-high reset.
- Req  in  2  per-source frame request, level. Source n must hold its first payload byte on ByteData{n} while Req[n] is high.
- Len0, Len1  in  9 each  payload byte count, sampled at grant.
- ByteData0, ByteData1  in  8 each  current payload byte of each source.
- ByteRd  out  2  one-cycle pulse. The byte on ByteData{n} is sampled at the end of this cycle, and the source advances to its next byte on the following cycle.
- Grant  out  2  one-hot, one-cycle pulse when a frame is accepted.
- DataO  out  1  serial TX bit.
- Active  out  1  high while ASM or payload bits are on DataO.
- Busy  out  1  high from the first ASM bit through the last gap bit.
- FrameDone  out  1  one-cycle pulse on the first gap cycle.
- Err  out  1  one-cycle pulse when a frame is rejected for its length.

## Operation
- States: IDLE → ASM → PAYLOAD → GAP → IDLE, plus the reject path IDLE → ERR → IDLE.
- Reset (Rst=1 at an edge): state goes to IDLE. DataO, Active, Busy, Grant, ByteRd, FrameDone and Err are all 0. The starvation counter clears. Rst has priority over everything, including mid-frame. The aborted frame is never resumed.
- Arbitration in IDLE when any Req bit is high:
  - Source 0 wins, except when Req[1]=1 and the starvation counter = STARVE_LIMIT; then source 1 wins.
  - Starvation counter: increments on a source-0 grant while Req[1]=1; clears on a source-0 grant while Req[1]=0; clears on any source-1 grant; saturates at STARVE_LIMIT.
- On grant the selected Len is latched.
  - If Len=0 or Len>MAX_LEN, go to ERR. Grant still pulses and Err pulses in the same cycle. No ByteRd, DataO stays 0, and the next state is IDLE with no gap.
  - Otherwise go to ASM.
- ASM: ASM_WIDTH cycles, DataO = ASM[ASM_WIDTH-1-i] on cycle i.
- PAYLOAD: 8×Len cycles, bytes sent MSB-first. ByteRd pulses exactly Len times per frame:
  - on the last ASM cycle, which loads byte 0;
  - on the 8th bit cycle of bytes 0..Len-2.
- Req changes after grant are ignored until the next IDLE. Req dropping mid-frame does not shorten the frame.
- GAP: GAP_BITS cycles with DataO=0, then one IDLE cycle with DataO=0 before the next grant can take effect.
- Bit counter is wide enough for max(8×MAX_LEN, GAP_BITS) with no wrap. Payload length arithmetic uses 9-bit Len × 8 held in a 12-bit count.

## Timing
- Edge t: IDLE samples Req. Cycle t+1: Grant=1, Busy=1, Active=1, DataO=ASM MSB.
- First payload bit (byte 0 bit 7) appears at cycle t+1+ASM_WIDTH.
- FrameDone and Busy fall:
  - FrameDone at cycle t+1+ASM_WIDTH+8×Len, when Active drops.
  - Busy falls after GAP_BITS gap cycles.
- Frame-to-frame grant period with Req held: ASM_WIDTH + 8×Len + GAP_BITS + 1 cycles. With the defaults and Len=274 this is 3209.
- Rejected frame: Grant and Err at t+1, IDLE at t+2, next grant at t+3 at the earliest.
- All outputs are registered. DataO has no combinational path from any input.

## Test plan
- Single frame: Req=01, Len0=2, bytes A5,3C. DataO = EB90 A53C MSB-first, then 1000 zeros. ByteRd[0] pulses at cycle 16 (last ASM cycle) and cycle 24. FrameDone at cycle 33 (Grant cycle = 1). Busy low at cycle 1033.
- Simultaneous requests: Req=11 from reset, both Len=1. Grant=01 first, then Grant=10 on the next frame while source 0 has been dropped. Each frame's payload comes only from its own ByteData.
- Starvation: Req=11 held, STARVE_LIMIT=4. Grant sequence is 0,0,0,0,1,0,0,0,0,1. The counter does not exceed 4.
- Length bounds: Len0=0 gives Grant=01 and Err together, DataO stays 0, no ByteRd, Busy stays 0. Len0=275 behaves the same. Len0=274 sends 2192 payload bits with exactly 274 ByteRd pulses.
- Reset mid-payload: assert Rst during byte 1. The next cycle has all outputs 0 and state IDLE. A subsequent Req restarts from the EB90 marker.
- Req dropped after grant: Req[0] falls one cycle after Grant. The full Len-byte frame and gap are still emitted.
